// File: rtl/chan_delay_reader.sv
// Per-channel x(k-1) store with a random-access valid/ready read port.
// Optional even-parity protection of stored entries under PARITY_CHECK_EN.
module chan_delay_reader #(
    parameter int               WIDTH       = 2,
    parameter int               CHANNELS    = 8,
    parameter int               CH_BITS     = 3,
    parameter logic [WIDTH-1:0] RESET_STATE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_stb,
    input  logic [CH_BITS-1:0] wr_ch,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_req,
    input  logic [CH_BITS-1:0] rd_ch,
    output logic               rd_busy,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [WIDTH-1:0]   rd_data,
    output logic [CH_BITS-1:0] rd_ch_out,
    output logic               rd_fresh,
    output logic               rd_range_err,
`ifdef PARITY_CHECK_EN
    output logic               rd_par_err,
`endif
    output logic [7:0]         wr_drop_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS+1)'(CHANNELS);

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    mem [CHANNELS];
    logic [CHANNELS-1:0] written;
    logic [CH_BITS-1:0]  ch_q;
    logic                wr_in_range, rd_in_range;

    assign wr_in_range = ({1'b0, wr_ch} < CH_LIMIT);
    assign rd_in_range = ({1'b0, ch_q} < CH_LIMIT);

    // Store and written flags; writes are never blocked by the read FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) mem[i] <= RESET_STATE;
            written     <= '0;
            wr_drop_cnt <= '0;
        end else if (wr_stb) begin
            if (wr_in_range) begin
                mem[wr_ch]     <= wr_data;
                written[wr_ch] <= 1'b1;
            end else if (wr_drop_cnt != 8'hff) begin
                wr_drop_cnt <= wr_drop_cnt + 8'd1;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic [CHANNELS-1:0] par;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par <= {CHANNELS{^RESET_STATE}};
        end else if (wr_stb && wr_in_range) begin
            par[wr_ch] <= ^wr_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_busy   = 1'b1;
        rd_valid  = 1'b0;
        case (state)
            IDLE: begin
                rd_busy = 1'b0;
                if (rd_req) state_nxt = FETCH;
            end
            FETCH: state_nxt = RESP;
            RESP: begin
                rd_valid = 1'b1;
                if (rd_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response capture reads mem before any same-edge write lands, giving x(k-1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q         <= '0;
            rd_data      <= RESET_STATE;
            rd_ch_out    <= '0;
            rd_fresh     <= 1'b0;
            rd_range_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            rd_par_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (rd_req) ch_q <= rd_ch;
                FETCH: begin
                    rd_ch_out <= ch_q;
                    if (rd_in_range) begin
                        rd_data      <= mem[ch_q];
                        rd_fresh     <= written[ch_q];
                        rd_range_err <= 1'b0;
`ifdef PARITY_CHECK_EN
                        rd_par_err   <= (^mem[ch_q]) != par[ch_q];
`endif
                    end else begin
                        rd_data      <= RESET_STATE;
                        rd_fresh     <= 1'b0;
                        rd_range_err <= 1'b1;
`ifdef PARITY_CHECK_EN
                        rd_par_err   <= 1'b0;
`endif
                    end
                end
                RESP: if (rd_ready) begin
                    rd_range_err <= 1'b0;
`ifdef PARITY_CHECK_EN
                    rd_par_err   <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chan_delay_reader.sv
// Directed bench for chan_delay_reader (CHANNELS=6 so ch 6/7 are out of range).
module tb_chan_delay_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_stb;
    logic [2:0] wr_ch;
    logic [1:0] wr_data;
    logic       rd_req;
    logic [2:0] rd_ch;
    logic       rd_busy;
    logic       rd_valid;
    logic       rd_ready;
    logic [1:0] rd_data;
    logic [2:0] rd_ch_out;
    logic       rd_fresh;
    logic       rd_range_err;
    logic [7:0] wr_drop_cnt;
`ifdef PARITY_CHECK_EN
    logic       rd_par_err;
`endif

    int checks = 0;
    int errors = 0;

    chan_delay_reader #(.WIDTH(2), .CHANNELS(6), .CH_BITS(3), .RESET_STATE(2'b00)) dut (
        .clk(clk), .reset(reset),
        .wr_stb(wr_stb), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_busy(rd_busy),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_ch_out(rd_ch_out), .rd_fresh(rd_fresh), .rd_range_err(rd_range_err),
`ifdef PARITY_CHECK_EN
        .rd_par_err(rd_par_err),
`endif
        .wr_drop_cnt(wr_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] d);
        wr_stb = 1'b1; wr_ch = ch; wr_data = d;
        @(negedge clk);
        wr_stb = 1'b0;
    endtask

    // Issue a request; returns at the negedge where the response is valid.
    task automatic start_read(input string tag, input logic [2:0] ch);
        rd_req = 1'b1; rd_ch = ch;
        @(negedge clk);
        rd_req = 1'b0;
        chk({tag, "_busy_fetch"}, rd_busy, 1'b1);
        chk({tag, "_novalid_fetch"}, rd_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_valid"}, rd_valid, 1'b1);
    endtask

    task automatic resp(input string tag, input logic [1:0] d, input logic f,
                        input logic re, input logic [2:0] ch);
        chk({tag, "_data"}, rd_data, d);
        chk({tag, "_fresh"}, rd_fresh, f);
        chk({tag, "_range"}, rd_range_err, re);
        chk({tag, "_ch"}, rd_ch_out, ch);
    endtask

    task automatic end_read(input string tag);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk({tag, "_done_valid"}, rd_valid, 1'b0);
        chk({tag, "_done_busy"}, rd_busy, 1'b0);
        chk({tag, "_done_range"}, rd_range_err, 1'b0);
    endtask

    initial begin
        reset = 1'b1; wr_stb = 0; wr_ch = 0; wr_data = 0;
        rd_req = 0; rd_ch = 0; rd_ready = 0;
        #2;
        chk("rst_busy", rd_busy, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ch", rd_ch_out, 0);
        chk("rst_fresh", rd_fresh, 0);
        chk("rst_range", rd_range_err, 0);
        chk("rst_drop", wr_drop_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Unwritten channel returns reset state
        start_read("r5", 3'd5);
        resp("r5", 2'b00, 1'b0, 1'b0, 3'd5);
        end_read("r5");

        // Written channel; response held while consumer stalls
        wr(3'd3, 2'b10);
        start_read("r3", 3'd3);
        resp("r3", 2'b10, 1'b1, 1'b0, 3'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_valid", rd_valid, 1'b1);
            chk("hold_busy", rd_busy, 1'b1);
            chk("hold_data", rd_data, 2'b10);
            chk("hold_ch", rd_ch_out, 3'd3);
        end
        end_read("r3");

        // Same-channel write on the FETCH-exit edge returns the old value
        wr(3'd2, 2'b01);
        rd_req = 1'b1; rd_ch = 3'd2;
        @(negedge clk);
        rd_req = 1'b0;
        wr_stb = 1'b1; wr_ch = 3'd2; wr_data = 2'b11;
        @(negedge clk);
        wr_stb = 1'b0;
        chk("xk1_valid", rd_valid, 1'b1);
        chk("xk1_data", rd_data, 2'b01);
        // Write during RESP leaves the held response alone
        wr(3'd2, 2'b00);
        chk("resp_wr_data", rd_data, 2'b01);
        end_read("xk1");
        start_read("r2b", 3'd2);
        resp("r2b", 2'b00, 1'b1, 1'b0, 3'd2);
        end_read("r2b");
        wr(3'd2, 2'b11);
        start_read("r2c", 3'd2);
        resp("r2c", 2'b11, 1'b1, 1'b0, 3'd2);
        end_read("r2c");

        // Out-of-range writes: count saturates
        for (int i = 0; i < 100; i++) wr(3'd7, 2'b11);
        chk("drop_100", wr_drop_cnt, 8'd100);
        for (int i = 0; i < 200; i++) wr(3'd7, 2'b11);
        chk("drop_sat", wr_drop_cnt, 8'd255);
        wr(3'd6, 2'b11);
        chk("drop_sat6", wr_drop_cnt, 8'd255);
        start_read("r7", 3'd7);
        resp("r7", 2'b00, 1'b0, 1'b1, 3'd7);
        end_read("r7");
        start_read("r6", 3'd6);
        resp("r6", 2'b00, 1'b0, 1'b1, 3'd6);
        end_read("r6");

        // Requests while busy are ignored
        rd_req = 1'b1; rd_ch = 3'd3;
        @(negedge clk);
        rd_ch = 3'd1;
        @(negedge clk);
        chk("busy_valid", rd_valid, 1'b1);
        @(negedge clk);
        resp("busy", 2'b10, 1'b1, 1'b0, 3'd3);
        rd_req = 1'b0;
        end_read("busy");
        @(negedge clk);
        chk("busy_idle", rd_busy, 1'b0);

        // Reset during RESP abandons the transaction and clears the store
        start_read("rr", 3'd3);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", rd_valid, 1'b0);
        chk("midrst_busy", rd_busy, 1'b0);
        chk("midrst_data", rd_data, 2'b00);
        chk("midrst_fresh", rd_fresh, 1'b0);
        chk("midrst_drop", wr_drop_cnt, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_valid", rd_valid, 1'b0);
        start_read("pr3", 3'd3);
        resp("pr3", 2'b00, 1'b0, 1'b0, 3'd3);
        end_read("pr3");
        start_read("pr2", 3'd2);
        resp("pr2", 2'b00, 1'b0, 1'b0, 3'd2);
        end_read("pr2");

`ifdef PARITY_CHECK_EN
        wr(3'd1, 2'b01);
        dut.mem[1] = 2'b00;
        start_read("par", 3'd1);
        chk("par_err", rd_par_err, 1'b1);
        chk("par_data", rd_data, 2'b00);
        end_read("par");
        chk("par_clr", rd_par_err, 1'b0);
        start_read("par_ok", 3'd4);
        chk("par_ok_err", rd_par_err, 1'b0);
        end_read("par_ok");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
